// File: rtl/src_ctrl_pkg.sv
// Shared constants and types for the Mini-SRC conditional-branch control slice.
package src_ctrl_pkg;

  localparam logic [4:0] BR_OPCODE = 5'b10010;

  // 3-bit state encoding kept as plain constants for compatibility with older decode logic
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_EVAL   = 3'd1;
  localparam logic [2:0] ST_LOADPC = 3'd2;
  localparam logic [2:0] ST_ADD    = 3'd3;
  localparam logic [2:0] ST_WRPC   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef struct packed {
    logic gra;
    logic r_out;
    logic con_in;
    logic pc_out;
    logic y_in;
    logic c_out;
    logic alu_add;
    logic z_in;
    logic zlow_out;
    logic pc_in;
  } strobe_t;

endpackage

// File: rtl/branch_sequencer_if.sv
// Decode-side request, CON feedback, datapath strobes and branch statistics of the sequencer.
interface branch_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [4:0]       opcode;
  logic             con;
  logic             busy;
  logic             done;
  logic             illegal;
  logic             gra;
  logic             r_out;
  logic             con_in;
  logic             pc_out;
  logic             y_in;
  logic             c_out;
  logic             alu_add;
  logic             z_in;
  logic             zlow_out;
  logic             pc_in;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] nottaken_cnt;

  // master: the sequencer itself; slave: decode stage / datapath side
  modport master (
    input  start, opcode, con,
    output busy, done, illegal, gra, r_out, con_in, pc_out, y_in,
           c_out, alu_add, z_in, zlow_out, pc_in, taken_cnt, nottaken_cnt
  );

  modport slave (
    output start, opcode, con,
    input  busy, done, illegal, gra, r_out, con_in, pc_out, y_in,
           c_out, alu_add, z_in, zlow_out, pc_in, taken_cnt, nottaken_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/branch_sequencer.sv
// Conditional-branch micro-sequencer: T3 CON evaluation, T4-T6 PC <- PC + C when taken.
module branch_sequencer #(
  parameter logic [4:0] BR_OPCODE = src_ctrl_pkg::BR_OPCODE,
  parameter int         CNT_W     = 16
) (
  input  logic               clock,
  input  logic               clear,
  branch_sequencer_if.master bus
);
  import src_ctrl_pkg::ST_IDLE;
  import src_ctrl_pkg::ST_EVAL;
  import src_ctrl_pkg::ST_LOADPC;
  import src_ctrl_pkg::ST_ADD;
  import src_ctrl_pkg::ST_WRPC;
  import src_ctrl_pkg::ST_DONE;
  import src_ctrl_pkg::strobe_t;

  logic [2:0] state_reg;
  logic [2:0] state_next;
  logic       illegal_reg;
  strobe_t    strobe;
  logic [1:0] inc;
  logic [CNT_W-1:0] cnt [2];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (bus.start) state_next = (bus.opcode == BR_OPCODE) ? ST_EVAL : ST_DONE;
      ST_EVAL:   state_next = ST_LOADPC;
      ST_LOADPC: state_next = bus.con ? ST_ADD : ST_DONE;
      ST_ADD:    state_next = ST_WRPC;
      ST_WRPC:   state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg   <= ST_IDLE;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && bus.start && bus.opcode != BR_OPCODE) begin
        illegal_reg <= 1'b1;
      end else if (state_reg == ST_DONE) begin
        illegal_reg <= 1'b0;
      end
    end
  end

  // Strobes are pure state decode (plus con in LOADPC), so reset forces them low at once
  always_comb begin
    strobe = '0;
    case (state_reg)
      ST_EVAL: begin
        strobe.gra    = 1'b1;
        strobe.r_out  = 1'b1;
        strobe.con_in = 1'b1;
      end
      ST_LOADPC: begin
        strobe.pc_out = bus.con;
        strobe.y_in   = bus.con;
      end
      ST_ADD: begin
        strobe.c_out   = 1'b1;
        strobe.alu_add = 1'b1;
        strobe.z_in    = 1'b1;
      end
      ST_WRPC: begin
        strobe.zlow_out = 1'b1;
        strobe.pc_in    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy     = (state_reg != ST_IDLE);
  assign bus.done     = (state_reg == ST_DONE);
  assign bus.illegal  = (state_reg == ST_DONE) && illegal_reg;
  assign bus.gra      = strobe.gra;
  assign bus.r_out    = strobe.r_out;
  assign bus.con_in   = strobe.con_in;
  assign bus.pc_out   = strobe.pc_out;
  assign bus.y_in     = strobe.y_in;
  assign bus.c_out    = strobe.c_out;
  assign bus.alu_add  = strobe.alu_add;
  assign bus.z_in     = strobe.z_in;
  assign bus.zlow_out = strobe.zlow_out;
  assign bus.pc_in    = strobe.pc_in;

  // Index 0 counts taken branches, index 1 not-taken ones
  assign inc[0] = (state_reg == ST_WRPC);
  assign inc[1] = (state_reg == ST_LOADPC) && !bus.con;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clock (clock),
        .clear (clear),
        .inc   (inc[gi]),
        .count (cnt[gi])
      );
    end
  endgenerate

  assign bus.taken_cnt    = cnt[0];
  assign bus.nottaken_cnt = cnt[1];

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomized bench for branch_sequencer: 16-bit and 2-bit counter instances driven in lockstep.
module tb_branch_sequencer;

  localparam logic [4:0] BR_OP = src_ctrl_pkg::BR_OPCODE;

  // word layout: busy | done illegal | gra r_out con_in | pc_out y_in | c_out alu_add z_in | zlow_out pc_in
  localparam logic [12:0] W_IDLE     = 13'b0_00_000_00_000_00;
  localparam logic [12:0] W_T3       = 13'b1_00_111_00_000_00;
  localparam logic [12:0] W_T4_TAKEN = 13'b1_00_000_11_000_00;
  localparam logic [12:0] W_T4_NOT   = 13'b1_00_000_00_000_00;
  localparam logic [12:0] W_T5       = 13'b1_00_000_00_111_00;
  localparam logic [12:0] W_T6       = 13'b1_00_000_00_000_11;
  localparam logic [12:0] W_END      = 13'b1_10_000_00_000_00;
  localparam logic [12:0] W_END_ILL  = 13'b1_11_000_00_000_00;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic       con = 1'b0;

  int total = 0;
  int bad = 0;
  int taken_raw = 0;
  int nottaken_raw = 0;
  int txn_no = 0;

  always #5 clock = ~clock;

  branch_sequencer_if #(.CNT_W(16)) if16 ();
  branch_sequencer_if #(.CNT_W(2))  if2 ();

  assign if16.start  = start;
  assign if16.opcode = opcode;
  assign if16.con    = con;
  assign if2.start   = start;
  assign if2.opcode  = opcode;
  assign if2.con     = con;

  branch_sequencer #(.CNT_W(16)) dut16 (.clock(clock), .clear(clear), .bus(if16.master));
  branch_sequencer #(.CNT_W(2))  dut2  (.clock(clock), .clear(clear), .bus(if2.master));

  logic [12:0] w16, w2;
  assign w16 = {if16.busy, if16.done, if16.illegal, if16.gra, if16.r_out, if16.con_in,
                if16.pc_out, if16.y_in, if16.c_out, if16.alu_add, if16.z_in,
                if16.zlow_out, if16.pc_in};
  assign w2  = {if2.busy, if2.done, if2.illegal, if2.gra, if2.r_out, if2.con_in,
                if2.pc_out, if2.y_in, if2.c_out, if2.alu_add, if2.z_in,
                if2.zlow_out, if2.pc_in};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int raw, input int maxv);
    return (raw > maxv) ? maxv : raw;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_taken16"},    32'(if16.taken_cnt),    32'(sat(taken_raw, 65535)));
    check({tag, "_nottaken16"}, 32'(if16.nottaken_cnt), 32'(sat(nottaken_raw, 65535)));
    check({tag, "_taken2"},     32'(if2.taken_cnt),     32'(sat(taken_raw, 3)));
    check({tag, "_nottaken2"},  32'(if2.nottaken_cnt),  32'(sat(nottaken_raw, 3)));
  endtask

  // Called at a falling edge with the sequencer idle; leaves it idle at a falling edge.
  task automatic run_txn(input logic [4:0] op, input logic c, input bit noisy);
    logic [12:0] exp_q[$];
    string kind;
    if (op != BR_OP) begin
      exp_q.push_back(W_END_ILL);
      kind = "illegal";
    end else if (c) begin
      exp_q.push_back(W_T3);
      exp_q.push_back(W_T4_TAKEN);
      exp_q.push_back(W_T5);
      exp_q.push_back(W_T6);
      exp_q.push_back(W_END);
      kind = "taken";
    end else begin
      exp_q.push_back(W_T3);
      exp_q.push_back(W_T4_NOT);
      exp_q.push_back(W_END);
      kind = "nottaken";
    end
    start  = 1'b1;
    opcode = op;
    con    = 1'($urandom_range(0, 1));
    @(posedge clock);
    @(negedge clock);
    for (int k = 1; k <= exp_q.size(); k++) begin
      check($sformatf("t%0d_cyc%0d_w16", txn_no, k), 32'(w16), 32'(exp_q[k-1]));
      check($sformatf("t%0d_cyc%0d_w2", txn_no, k),  32'(w2),  32'(exp_q[k-1]));
      start  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      opcode = noisy ? 5'($urandom_range(0, 31)) : op;
      // con must hold across the whole T4 cycle and its closing edge
      con    = (k <= 2) ? c : 1'($urandom_range(0, 1));
      @(posedge clock);
      @(negedge clock);
    end
    if (op == BR_OP) begin
      if (c) taken_raw++;
      else   nottaken_raw++;
    end
    check($sformatf("t%0d_idle_w16", txn_no), 32'(w16), 32'(W_IDLE));
    check($sformatf("t%0d_idle_w2", txn_no),  32'(w2),  32'(W_IDLE));
    check_counters($sformatf("t%0d", txn_no));
    start = 1'b0;
    $display("txn %0d op=%b con=%b kind=%s taken16=%0d nottaken16=%0d taken2=%0d nottaken2=%0d",
             txn_no, op, c, kind, if16.taken_cnt, if16.nottaken_cnt, if2.taken_cnt, if2.nottaken_cnt);
    txn_no++;
  endtask

  initial begin
    int dones;
    logic [4:0] op;

    #12;
    check("reset_w16", 32'(w16), 32'(W_IDLE));
    check("reset_w2",  32'(w2),  32'(W_IDLE));
    check_counters("reset");
    @(negedge clock);
    clear = 1'b1;

    // taken branches; the 2-bit instance must read 1,2,3,3
    for (int i = 0; i < 4; i++) run_txn(BR_OP, 1'b1, 1'b0);
    run_txn(BR_OP, 1'b0, 1'b0);
    run_txn(5'b00011, 1'b1, 1'b0);

    // start held for ten edges: only two sequences may run
    start = 1'b1; opcode = BR_OP; con = 1'b1;
    dones = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (if16.done) dones++;
      if (i == 9) start = 1'b0;
    end
    taken_raw += 2;
    check("held_start_dones", 32'(dones), 32'd2);
    check_counters("held_start");
    $display("txn %0d held start: dones=%0d taken16=%0d", txn_no, dones, if16.taken_cnt);
    txn_no++;

    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 3) != 0) ? BR_OP : 5'($urandom_range(0, 31));
      run_txn(op, 1'($urandom_range(0, 1)), 1'b1);
    end

    // asynchronous clear in the middle of the T5 (ADD) cycle
    start = 1'b1; opcode = BR_OP; con = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    check("pre_clear_add_w16", 32'(w16), 32'(W_T5));
    clear = 1'b0;
    #1;
    taken_raw = 0;
    nottaken_raw = 0;
    check("clear_w16", 32'(w16), 32'(W_IDLE));
    check("clear_w2",  32'(w2),  32'(W_IDLE));
    check_counters("clear");
    $display("txn %0d async clear during add", txn_no);
    txn_no++;
    @(negedge clock);
    clear = 1'b1;
    run_txn(BR_OP, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
